// File: rtl/rdesplazante_param.sv
// -----------------------------------------------------------------------------
// rdesplazante_param
// Parametrised universal shift register. It supports serial shift, circular
// rotate, parallel load and hold, one operation per enabled cycle. A START/AMT
// command runs AMT shift or rotate steps, one per enabled cycle. BUSY reports
// the operation in progress and DONE gives a one-cycle completion pulse.
//
// Optional feature: define RDESP_PARITY_EN to add the registered PARITY output.
//
// Parameters
//   WIDTH  register width (>= 2)
//   CW     width of amt, derived as $clog2(WIDTH+1); not overridable
//
// Ports
//   clk     in   1      clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   enb     in   1      0 freezes q, s_out and the step counter
//   dir     in   1      0 = left (toward MSB), 1 = right (toward LSB)
//   s_in    in   1      serial input bit
//   mode    in   2      00 shift, 01 rotate, 10 parallel load, 11 hold
//   d       in   WIDTH  parallel load data
//   start   in   1      begin a multi-step shift/rotate of amt positions
//   amt     in   CW     step count for start (0..2^CW-1)
//   q       out  WIDTH  register contents
//   s_out   out  1      bit that left the register on the last step
//   busy    out  1      multi-step operation in progress
//   done    out  1      one-cycle pulse when a multi-step operation completes
//   parity  out  1      ^q, only with RDESP_PARITY_EN
// -----------------------------------------------------------------------------
module rdesplazante_param #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CW-1:0]    amt,
  output logic [WIDTH-1:0] q,
`ifdef RDESP_PARITY_EN
  output logic             parity,
`endif
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic             s_out_r, s_out_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             rot_r, rot_nxt_s;   // latched MODE[0] for the running operation
  logic             dir_r, dir_nxt_s;   // latched DIR for the running operation
  logic             busy_r;
  logic             done_r;

  // One shift/rotate step. On a rotate the incoming bit is the bit that leaves
  // the register. On a shift the incoming bit is the serial input.
  function automatic logic [WIDTH-1:0] step_q(input logic [WIDTH-1:0] cur,
                                              input logic rot,
                                              input logic right,
                                              input logic sin);
    logic fill;
    fill = rot ? (right ? cur[0] : cur[WIDTH-1]) : sin;
    return right ? {fill, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], fill};
  endfunction

  // Bit leaving the register on a step in the given direction.
  function automatic logic step_out(input logic [WIDTH-1:0] cur, input logic right);
    return right ? cur[0] : cur[WIDTH-1];
  endfunction

`ifdef RDESP_PARITY_EN
  // Even-parity reduction of a register value.
  function automatic logic parity_f(input logic [WIDTH-1:0] val);
    return ^val;
  endfunction
`endif

  // Next-state and datapath decision for the IDLE/RUN/FIN sequencer.
  always_comb begin
    q_nxt_s     = q_r;
    s_out_nxt_s = s_out_r;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rot_nxt_s   = rot_r;
    dir_nxt_s   = dir_r;
    case (state_r)
      ST_IDLE: begin
        if (enb) begin
          if (start && (mode[1] == 1'b0)) begin
            rot_nxt_s = mode[0];
            dir_nxt_s = dir;
            if (amt == {CW{1'b0}}) begin
              // A zero-length command still reports completion.
              state_nxt_s = ST_FIN;
            end else begin
              q_nxt_s     = step_q(q_r, mode[0], dir, s_in);
              s_out_nxt_s = step_out(q_r, dir);
              if (amt == CW'(1'b1)) begin
                state_nxt_s = ST_FIN;
              end else begin
                cnt_nxt_s   = amt - CW'(1'b1);
                state_nxt_s = ST_RUN;
              end
            end
          end else begin
            case (mode)
              2'b00: begin
                q_nxt_s     = step_q(q_r, 1'b0, dir, s_in);
                s_out_nxt_s = step_out(q_r, dir);
              end
              2'b01: begin
                q_nxt_s     = step_q(q_r, 1'b1, dir, s_in);
                s_out_nxt_s = step_out(q_r, dir);
              end
              2'b10: begin
                q_nxt_s     = d;
                s_out_nxt_s = 1'b0;
              end
              default: begin
                q_nxt_s     = q_r;
                s_out_nxt_s = s_out_r;
              end
            endcase
          end
        end else begin
          q_nxt_s = q_r;
        end
      end
      ST_RUN: begin
        if (enb) begin
          q_nxt_s     = step_q(q_r, rot_r, dir_r, s_in);
          s_out_nxt_s = step_out(q_r, dir_r);
          cnt_nxt_s   = cnt_r - CW'(1'b1);
          if (cnt_r == CW'(1'b1)) begin
            state_nxt_s = ST_FIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and status registers. BUSY/DONE are decoded from the next
  // state so that they align with the cycle the FSM sits in RUN/FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      q_r     <= {WIDTH{1'b0}};
      s_out_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      rot_r   <= 1'b0;
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      q_r     <= q_nxt_s;
      s_out_r <= s_out_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rot_r   <= rot_nxt_s;
      dir_r   <= dir_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_FIN);
    end
  end

`ifdef RDESP_PARITY_EN
  logic parity_r;

  // Parity register tracking the value q takes on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity_f(q_nxt_s);
    end
  end

  assign parity = parity_r;
`endif

  assign q     = q_r;
  assign s_out = s_out_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule
